fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage driving the 12-bit instruction memory address and registering the returned 19-bit word for decode. Holds the program counter, supports stall, jump redirect, and subroutine call/return through an internal return-address stack, and flushes the wrong-path word on any control transfer. Sits between the execute/decode control signals and the combinational instruction memory.

## Interface
- ADDR_W, 12, instruction address width
- INS_W, 19, instruction word width
- STACK_DEPTH, 8, return-stack entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC, IR and ir_valid this cycle
- redirect  in  1  jump to target (plain branch/jump)
- call  in  1  push return address, jump to target
- ret  in  1  pop return address, jump to it
- target  in  ADDR_W  jump/call destination
- imem_addr  out  ADDR_W  address to instruction memory (= pc)
- imem_data  in  INS_W  combinational read data for imem_addr
- ir  out  INS_W  registered instruction for decode
- ir_pc  out  ADDR_W  address of the word held in ir
- ir_valid  out  1  ir holds a valid, non-flushed word
- stack_overflow  out  1  sticky: call with stack full
- stack_underflow  out  1  sticky: ret with stack empty

## Operation
- Registers: pc, ir, ir_pc, ir_valid, stack[STACK_DEPTH], sp (0..STACK_DEPTH, count of valid entries), two sticky flags.
- imem_addr = pc combinationally; imem_data assumed valid in the same cycle.
- Control priority per cycle: ret > call > redirect > stall > sequential. Lower-priority control inputs asserted alongside are ignored.
- Sequential (no control, no stall): ir ← imem_data, ir_pc ← pc, ir_valid ← 1, pc ← pc+1 (mod 2^ADDR_W, 4095 → 0).
- Stall (no control): pc, ir, ir_pc, ir_valid, sp unchanged.
- Control transfer (overrides stall): ir_valid ← 0 (flush word at pc), ir/ir_pc unchanged, pc ← new target.
  - redirect: pc ← target.
  - call: return address = ir_pc+1 (mod 2^ADDR_W). If sp < STACK_DEPTH: stack[sp] ← ret addr, sp ← sp+1. If full: push dropped, stack_overflow ← 1. pc ← target either way.
  - ret: if sp > 0: pc ← stack[sp-1], sp ← sp-1. If empty: pc ← 0, sp stays 0, stack_underflow ← 1.
- Sticky flags clear only on reset.
- Control inputs are generated from the word in ir; the block does not gate them with ir_valid.

## Timing
- Reset (async assert, any time, including mid-stall/mid-call): pc=0, ir=0, ir_pc=0, ir_valid=0, sp=0, stack_overflow=0, stack_underflow=0; stack contents don't-care. Deassertion is sampled synchronously; first edge after release loads ins[0].
- Fetch latency: 1 cycle from pc to ir.
- Transfer penalty: 1 bubble. Control at edge N → ir_valid=0 after N; word at target appears in ir with ir_valid=1 after edge N+1 (if not stalled).
- Call at full stack and ret at empty stack still complete the jump in the same cycle.
- Stall asserted while ir_valid=0 keeps the bubble; stall has no effect on stack or flags.

## Test plan
- Reset then 5 free-running cycles with ins[k]=k+0x100: ir sequence 0x100..0x104, ir_pc 0..4, ir_valid 1 from first edge; assert rst_n low mid-run → all outputs zero immediately.
- Stall at pc=3 for 2 cycles: ir/ir_pc (=2)/ir_valid held, imem_addr stays 3; release → ir_pc 3 next edge.
- redirect with target=10 while ir_pc=4: next cycle ir_valid=0, imem_addr=10; following cycle ir_pc=10, ir_valid=1; simultaneous stall ignored.
- call target=20 at ir_pc=6, then ret at ir_pc=21: pc 20, sp 1, then pc 7, sp 0; each with one bubble.
- STACK_DEPTH+1 nested calls: stack_overflow=1 on last, sp stays 8, jump taken; then 9 rets: 8 return correct addresses LIFO, 9th → pc=0, stack_underflow=1.
- pc=4095 sequential → imem_addr 0; call at ir_pc=4095 pushes 0; call and ret same cycle → ret wins.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IR register and return-address stack; one-cycle pc->ir latency.
// Stall holds PC/IR/valid; ret > call > redirect override stall and flush with one bubble.
module fetch_stage #(
   parameter int ADDR_W      = 12,
   parameter int INS_W       = 19,
   parameter int STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INS_W-1:0]  imem_data,
   output logic [INS_W-1:0]  ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   output logic              stack_overflow,
   output logic              stack_underflow
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INS_W-1:0]  ir_q, ir_d;
   logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
   logic              ir_valid_q, ir_valid_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

   logic              push_en;
   logic [ADDR_W-1:0] push_dat;
   logic [SP_W-1:0]   sp_m1;

   assign sp_m1 = sp_q - 1'b1;

   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      sp_d       = sp_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      push_en    = 1'b0;
      push_dat   = ir_pc_q + 1'b1;
      if (ret) begin
         ir_valid_d = 1'b0;
         if (sp_q != '0) begin
            pc_d = stack_q[sp_m1[IDX_W-1:0]];
            sp_d = sp_m1;
         end else begin
            pc_d  = '0;
            unf_d = 1'b1;
         end
      end else if (call) begin
         ir_valid_d = 1'b0;
         pc_d       = target;
         if (sp_q != SP_FULL) begin
            push_en = 1'b1;
            sp_d    = sp_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (redirect) begin
         ir_valid_d = 1'b0;
         pc_d       = target;
      end else if (!stall) begin
         ir_d       = imem_data;
         ir_pc_d    = pc_q;
         ir_valid_d = 1'b1;
         pc_d       = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         sp_q       <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         sp_q       <= sp_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Stack contents are meaningless while sp counts them invalid, so no reset here.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[sp_q[IDX_W-1:0]] <= push_dat;
      end
   end

   assign imem_addr       = pc_q;
   assign ir              = ir_q;
   assign ir_pc           = ir_pc_q;
   assign ir_valid        = ir_valid_q;
   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;

endmodule
